// File: rtl/crc_frame_builder.sv
// crc_frame_builder
//   Buffers one frame of upstream bytes while computing a CRC-8
//   (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR), then emits
//   the byte count on the count channel, followed by the payload bytes and the
//   CRC byte on the data channel.
//
// Handshake: every channel moves a beat only in a cycle where valid and ready
//   are both high. An output valid, once raised, stays high with its data held
//   stable until that transfer happens. in_ready is high only in FILL.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream byte handshake; in_data, in_last qualify it
//   count_valid/ready   count channel; count_data = payload bytes in frame
//   data_valid/ready    data channel; data_out = payload bytes then CRC
//   dbg_state           current FSM state (FILL=0, SEND_COUNT=1,
//                       SEND_DATA=2, SEND_CRC=3)
module crc_frame_builder #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       count_valid,
  input  logic       count_ready,
  output logic [7:0] count_data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic [1:0] dbg_state
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    SEND_COUNT = 2'd1,
    SEND_DATA  = 2'd2,
    SEND_CRC   = 2'd3
  } state_e;

  state_e     state_q;
  logic [7:0] mem_q [2**AW];
  logic [7:0] n_q;          // bytes accepted in the current frame
  logic [7:0] rd_idx_q;     // next buffer entry to load into data_out
  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       in_ready_q;
  logic       count_valid_q;
  logic [7:0] count_data_q;
  logic       data_valid_q;
  logic [7:0] data_out_q;
  logic       accept;
  logic       full;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign accept = in_ready_q & in_valid;
  assign full   = (n_q == LAST_IDX);  // this byte is number DEPTH
  assign crc_d  = crc8_byte(crc_q, in_data);

  // Payload storage: contents are only ever read after being written in the
  // same frame, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[n_q[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      n_q           <= 8'd0;
      rd_idx_q      <= 8'd0;
      crc_q         <= 8'd0;
      in_ready_q    <= 1'b0;
      count_valid_q <= 1'b0;
      count_data_q  <= 8'd0;
      data_valid_q  <= 1'b0;
      data_out_q    <= 8'd0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            crc_q <= crc_d;
            n_q   <= n_q + 8'd1;
            // in_last or buffer exhaustion closes the frame
            if (in_last || full) begin
              state_q       <= SEND_COUNT;
              in_ready_q    <= 1'b0;
              count_valid_q <= 1'b1;
              count_data_q  <= n_q + 8'd1;
            end
          end
        end
        SEND_COUNT: begin
          if (count_ready) begin
            // Preload the first payload byte so data follows with no gap.
            count_valid_q <= 1'b0;
            data_valid_q  <= 1'b1;
            data_out_q    <= mem_q[0];
            rd_idx_q      <= 8'd1;
            state_q       <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (data_ready) begin
            if (rd_idx_q == n_q) begin
              data_out_q <= crc_q;
              state_q    <= SEND_CRC;
            end else begin
              data_out_q <= mem_q[rd_idx_q[AW-1:0]];
              rd_idx_q   <= rd_idx_q + 8'd1;
            end
          end
        end
        SEND_CRC: begin
          if (data_ready) begin
            data_valid_q <= 1'b0;
            data_out_q   <= 8'd0;
            n_q          <= 8'd0;
            rd_idx_q     <= 8'd0;
            crc_q        <= 8'd0;
            in_ready_q   <= 1'b1;
            state_q      <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign count_valid = count_valid_q;
  assign count_data  = count_data_q;
  assign data_valid  = data_valid_q;
  assign data_out    = data_out_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_crc_frame_builder.sv
// Directed testbench for crc_frame_builder (DEPTH = 16).
module tb_crc_frame_builder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       count_valid;
  logic       count_ready;
  logic [7:0] count_data;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] data_out;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: data entries carry bit 8 = "this is the CRC byte".
  logic [8:0] exp_q[$];
  logic [7:0] cnt_q[$];
  int         n_data_seen = 0;
  bit         crc_seen = 0;
  bit         rand_mode = 0;

  logic       prev_cv, prev_cr, prev_dv, prev_dr;
  logic [7:0] prev_cd, prev_do;

  crc_frame_builder #(.DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .count_valid (count_valid),
    .count_ready (count_ready),
    .count_data  (count_data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference CRC-8, poly 0x07, MSB-first.
  function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Queue the expected output of an incrementing-byte frame.
  task automatic push_ramp(input logic [7:0] first, input int len);
    logic [7:0] c;
    c = 8'h00;
    cnt_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({1'b0, 8'(first + 8'(i))});
      c = crc8_ref(c, 8'(first + 8'(i)));
    end
    exp_q.push_back({1'b1, c});
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        check("send_timeout", {7'b0, in_ready}, 8'h01);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || cnt_q.size() != 0) && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 8'(exp_q.size() + cnt_q.size()), 8'h00);
    @(posedge clk);
    #1;
  endtask

  // Random data_ready backpressure.
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      data_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      check("valid_excl", {7'b0, count_valid & data_valid}, 8'h00);
      check("rdy_excl", {7'b0, in_ready & (count_valid | data_valid)}, 8'h00);
      if (crc_seen) begin
        check("rdy_after_crc", {7'b0, in_ready}, 8'h01);
        crc_seen = 0;
      end
      if (prev_cv && !prev_cr) begin
        check("cnt_hold_v", {7'b0, count_valid}, 8'h01);
        check("cnt_hold_d", count_data, prev_cd);
      end
      if (prev_dv && !prev_dr) begin
        check("dat_hold_v", {7'b0, data_valid}, 8'h01);
        check("dat_hold_d", data_out, prev_do);
      end
      if (count_valid && count_ready) begin
        if (cnt_q.size() == 0) check("cnt_unexp", {7'b0, count_valid}, 8'h00);
        else check("count", count_data, cnt_q.pop_front());
      end
      if (data_valid && data_ready) begin
        n_data_seen++;
        if (exp_q.size() == 0) check("dat_unexp", {7'b0, data_valid}, 8'h00);
        else begin
          e = exp_q.pop_front();
          check(e[8] ? "crc" : "data", data_out, e[7:0]);
          if (e[8]) crc_seen = 1;
        end
      end
      prev_cv = count_valid; prev_cr = count_ready; prev_cd = count_data;
      prev_dv = data_valid;  prev_dr = data_ready;  prev_do = data_out;
    end else begin
      prev_cv = 1'b0; prev_dv = 1'b0; crc_seen = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int target;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    count_ready = 1'b1; data_ready = 1'b1;
    prev_cv = 0; prev_cr = 0; prev_dv = 0; prev_dr = 0; prev_cd = 0; prev_do = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {7'b0, in_ready}, 8'h00);
    check("rst_count_valid", {7'b0, count_valid}, 8'h00);
    check("rst_count_data", count_data, 8'h00);
    check("rst_data_valid", {7'b0, data_valid}, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_state", {6'b0, dbg_state}, 8'h00);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_pre", {7'b0, in_ready}, 8'h00);
    @(posedge clk);
    #1;
    check("rel_in_ready_post", {7'b0, in_ready}, 8'h01);

    // "123456789" -> count 9, CRC 0xF4
    cnt_q.push_back(8'd9);
    for (int b = 8'h31; b <= 8'h39; b++) exp_q.push_back({1'b0, 8'(b)});
    exp_q.push_back({1'b1, 8'hF4});
    for (int b = 8'h31; b <= 8'h39; b++) send_byte(8'(b), b == 8'h39);
    check("count_latency", {7'b0, count_valid}, 8'h01);
    check("fill_closed", {7'b0, in_ready}, 8'h00);
    drain();
    check("ready_after_frame", {7'b0, in_ready}, 8'h01);

    // Single bytes
    cnt_q.push_back(8'd1); exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b1, 8'h07});
    send_byte(8'h01, 1'b1);
    drain();
    cnt_q.push_back(8'd1); exp_q.push_back({1'b0, 8'hFF}); exp_q.push_back({1'b1, 8'hF3});
    send_byte(8'hFF, 1'b1);
    drain();

    // Implicit last at DEPTH: 0x00..0x0F close frame 1, 0x10..0x14 form frame 2
    push_ramp(8'h00, 16);
    push_ramp(8'h10, 5);
    for (int b = 0; b < 16; b++) send_byte(8'(b), 1'b0);
    check("full_count_valid", {7'b0, count_valid}, 8'h01);
    check("full_in_ready", {7'b0, in_ready}, 8'h00);
    for (int b = 16; b < 20; b++) send_byte(8'(b), 1'b0);
    send_byte(8'h14, 1'b1);
    drain();

    // Backpressure: count_ready low 5 cycles, then random data_ready
    count_ready = 1'b0;
    push_ramp(8'hA1, 5);
    for (int b = 0; b < 5; b++) send_byte(8'(8'hA1 + 8'(b)), b == 4);
    repeat (5) @(posedge clk);
    #1;
    check("bp_count_held", {7'b0, count_valid}, 8'h01);
    count_ready = 1'b1;
    rand_mode = 1;
    drain();
    rand_mode = 0;
    @(posedge clk);
    #2;
    data_ready = 1'b1;

    // Reset mid-frame after 2 payload bytes emitted
    push_ramp(8'hC0, 4);
    target = n_data_seen + 2;
    for (int b = 0; b < 4; b++) send_byte(8'(8'hC0 + 8'(b)), b == 3);
    for (int t = 0; t < 200 && n_data_seen < target; t++) @(negedge clk);
    check("rst_wait", 8'(n_data_seen - target + 2), 8'h02);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data_valid", {7'b0, data_valid}, 8'h00);
    check("mid_rst_count_valid", {7'b0, count_valid}, 8'h00);
    check("mid_rst_in_ready", {7'b0, in_ready}, 8'h00);
    exp_q.delete();
    cnt_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {7'b0, in_ready}, 8'h01);
    check("post_rst_data_valid", {7'b0, data_valid}, 8'h00);
    cnt_q.push_back(8'd1); exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b1, 8'h07});
    send_byte(8'h01, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
